// File: rtl/debounced_encoder.sv
// Debounced 4-line priority encoder with a valid/ack handshake.
// Optional build macro ENCODER_COUNT_EN adds the evt_count handshake counter.
//
// state    | meaning
// IDLE     | lines idle, waiting for any nonzero input
// DEBOUNCE | nonzero pattern captured, counting stable samples
// HOLD     | code/multi presented with valid high, waiting for ack
// RELEASE  | accepted, waiting for all lines to return to zero
module debounced_encoder #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    input  logic       ack,
    output logic [1:0] code,
    output logic       valid,
    output logic       multi
`ifdef ENCODER_COUNT_EN
    ,
    output logic [7:0] evt_count
`endif
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] cap;

    function automatic logic [1:0] prio_code(input logic [3:0] p);
        logic [1:0] c;
        casez (p)
            4'b1???: c = 2'd3;
            4'b01??: c = 2'd2;
            4'b001?: c = 2'd1;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic is_multi(input logic [3:0] p);
        return (p & (p - 4'd1)) != 4'd0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
            code  <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
`ifdef ENCODER_COUNT_EN
            evt_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in != 4'd0) begin
                        cap   <= in;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (in == 4'd0) begin
                        state <= IDLE;
                    end else if (in != cap) begin
                        cap <= in;
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HOLD;
                        code  <= prio_code(cap);
                        multi <= is_multi(cap);
                        valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= RELEASE;
`ifdef ENCODER_COUNT_EN
                        evt_count <= evt_count + 8'd1;
`endif
                    end
                end
                RELEASE: begin
                    if (in == 4'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/debounced_encoder.md
DEBOUNCED_ENCODER -- requirements
Module: debounced_encoder

Interface
REQ-001 Parameter: DB_CYCLES, default 4, number of consecutive stable samples required after first detection (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in  input  4  line inputs, active high; bit 0 = line a, bit 3 = line d.
REQ-005 Port: ack  input  1  consumer accepts the presented code.
REQ-006 Port: code  output  2  registered binary index of the highest set bit of the accepted input pattern.
REQ-007 Port: valid  output  1  registered; code/multi are meaningful while high.
REQ-008 Port: multi  output  1  registered; more than one bit of the accepted pattern was set.
REQ-009 Only clk and rst are clock/reset; the block has no other clock or reset input.

Function
REQ-010 The FSM SHALL have four states: IDLE, DEBOUNCE, HOLD, RELEASE; an 8-bit counter cnt and a 4-bit capture register cap.
REQ-011 IDLE: in != 0 on an edge -> cap <= in, cnt <= 0, go DEBOUNCE; in == 0 -> stay.
REQ-012 DEBOUNCE: in == 0 -> IDLE; in != cap and in != 0 -> cap <= in, cnt <= 0, stay in DEBOUNCE.
REQ-013 DEBOUNCE: in == cap and cnt == DB_CYCLES-1 -> go HOLD, load code/multi from cap, valid <= 1; else cnt <= cnt+1.
REQ-014 Latency: valid SHALL rise on the (DB_CYCLES+1)th consecutive rising edge that samples the same nonzero in.
REQ-015 Encoding SHALL be priority, highest index wins: 1xxx->3, 01xx->2, 001x->1, 0001->0.
REQ-016 multi SHALL be 1 when cap has two or more bits set, else 0.
REQ-017 HOLD: valid, code, multi SHALL stay constant regardless of in; ack sampled high -> valid <= 0, go RELEASE.
REQ-018 RELEASE: in == 0 on an edge -> IDLE; otherwise stay; no new code is produced until in has returned to 0.
REQ-019 ack outside HOLD SHALL be ignored.
REQ-020 code and multi SHALL retain their last value after valid falls until the next HOLD entry.
REQ-021 cnt SHALL never wrap: it is only incremented while below DB_CYCLES-1.

Reset
REQ-022 rst high SHALL immediately (asynchronously) force state IDLE, cnt 0, cap 0, code 0, valid 0, multi 0.
REQ-023 Reset asserted in any state, including mid-DEBOUNCE or HOLD, SHALL drop valid without waiting for a clock edge.
REQ-024 After rst deasserts, a still-held nonzero in SHALL be treated as a new detection from IDLE.

Configuration
REQ-025 Macro ENCODER_COUNT_EN, when defined, SHALL add output port evt_count (8 bits) counting completed handshakes (edges with HOLD and ack high).
REQ-026 evt_count SHALL reset to 0 under rst and wrap 255 -> 0.
REQ-027 When ENCODER_COUNT_EN is not defined, evt_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 DB_CYCLES=4, in=4'b0100 held 6 edges, ack=0 -> valid=1 after 5th edge, code=2, multi=0, held constant.
REQ-029 in=4'b1010 stable, then ack=1 one cycle -> code=3, multi=1; valid=0 after ack edge; state RELEASE until in=0.
REQ-030 in=4'b0001 for 3 edges, then 4'b0010 -> cnt restarts; valid rises 5 edges after the change with code=1.
REQ-031 in=4'b1000 for 2 edges then 0 -> valid never asserts, FSM returns to IDLE.
REQ-032 rst pulsed mid-HOLD between clock edges -> valid, code, multi go to 0 before next edge.
REQ-033 With ENCODER_COUNT_EN defined, 257 complete press/ack/release cycles -> evt_count=1.
